// File: rtl/lsu_tlbrd_ctl.sv
// DTLB diagnostic/ASI read sequencer: round-robin grant across strands, one read
// in flight at a time, captured result returned through a valid/ready handshake.
module lsu_tlbrd_ctl #(
    parameter int NTHR   = 4,
    parameter int RD_LAT = 2
) (
    input  logic              rclk,
    input  logic              arst_l,
    input  logic [NTHR-1:0]   req_vld,
    input  logic [NTHR-1:0]   req_data_sel,
    input  logic [6*NTHR-1:0] req_entry,
    input  logic [NTHR-1:0]   req_cancel,
    input  logic              tlb_busy,
    output logic              tlb_rd_vld,
    output logic [5:0]        tlb_rd_entry,
    output logic              lsu_tlb_data_rd_vld_g,
    input  logic [63:0]       lsu_tlb_rd_data,
    input  logic              tte_data_parity_error,
    input  logic              tte_tag_parity_error,
    output logic [NTHR-1:0]   req_ack,
    output logic              rsp_vld,
    output logic [1:0]        rsp_tid,
    output logic [63:0]       rsp_data,
    output logic              rsp_perr,
    input  logic              rsp_rdy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] last_tid, tid, gnt_tid, idx;
    logic       gnt_any;
    logic       sel;
    logic [2:0] cnt;
    logic       drop;
    logic       cxl_pend;
    logic       cancel;
    logic       iss_cxl;
    logic       capture;

    assign cancel  = req_cancel[tid];
    // a cancel seen in the grant cycle is remembered and applied in ISSUE
    assign iss_cxl = cancel | cxl_pend;
    assign capture = (state == WAIT) && (cnt == 3'd1);

    always_comb begin
        gnt_any = 1'b0;
        gnt_tid = 2'd0;
        idx     = 2'd0;
        for (int i = 0; i < NTHR; i++) begin
            idx = last_tid + 2'(i + 1);
            if (!gnt_any && req_vld[idx]) begin
                gnt_any = 1'b1;
                gnt_tid = idx;
            end
        end
    end

    always_comb begin
        state_nxt             = state;
        req_ack               = '0;
        tlb_rd_vld            = 1'b0;
        lsu_tlb_data_rd_vld_g = 1'b0;
        rsp_vld               = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    req_ack[gnt_tid] = 1'b1;
                    state_nxt        = ISSUE;
                end
            end
            ISSUE: begin
                tlb_rd_vld            = ~tlb_busy;
                lsu_tlb_data_rd_vld_g = sel;
                if (tlb_busy && iss_cxl)
                    state_nxt = IDLE;
                else if (!tlb_busy)
                    state_nxt = WAIT;
            end
            WAIT: begin
                lsu_tlb_data_rd_vld_g = sel;
                if (cnt == 3'd1)
                    state_nxt = (drop || cancel) ? IDLE : RESP;
            end
            RESP: begin
                rsp_vld = 1'b1;
                if (cancel || rsp_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state        <= IDLE;
            last_tid     <= 2'd3;
            tid          <= 2'd0;
            sel          <= 1'b0;
            cnt          <= 3'd0;
            drop         <= 1'b0;
            cxl_pend     <= 1'b0;
            tlb_rd_entry <= 6'd0;
            rsp_tid      <= 2'd0;
            rsp_data     <= 64'd0;
            rsp_perr     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        tid          <= gnt_tid;
                        sel          <= req_data_sel[gnt_tid];
                        tlb_rd_entry <= req_entry[6*int'(gnt_tid) +: 6];
                        last_tid     <= gnt_tid;
                        cxl_pend     <= req_cancel[gnt_tid];
                    end
                end
                ISSUE: begin
                    if (state_nxt != ISSUE)
                        cxl_pend <= 1'b0;
                    if (!tlb_busy) begin
                        cnt  <= 3'(RD_LAT);
                        drop <= iss_cxl;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cancel)
                        drop <= 1'b1;
                    if (capture) begin
                        drop     <= 1'b0;
                        rsp_tid  <= tid;
                        rsp_data <= lsu_tlb_rd_data;
                        rsp_perr <= sel ? tte_data_parity_error : tte_tag_parity_error;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_tlbrd_ctl.sv
// Directed bench for lsu_tlbrd_ctl: grant order, latency, busy stall,
// backpressure/parity, cancel and reset behaviour with hand-derived expectations.
module tb_lsu_tlbrd_ctl;

    logic        rclk = 1'b0;
    logic        arst_l;
    logic [3:0]  req_vld, req_data_sel, req_cancel;
    logic [23:0] req_entry;
    logic        tlb_busy;
    logic        tlb_rd_vld;
    logic [5:0]  tlb_rd_entry;
    logic        lsu_tlb_data_rd_vld_g;
    logic [63:0] lsu_tlb_rd_data;
    logic        tte_data_parity_error, tte_tag_parity_error;
    logic [3:0]  req_ack;
    logic        rsp_vld;
    logic [1:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        rsp_perr;
    logic        rsp_rdy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 rclk = ~rclk;

    lsu_tlbrd_ctl #(.NTHR(4), .RD_LAT(2)) dut (
        .rclk(rclk), .arst_l(arst_l),
        .req_vld(req_vld), .req_data_sel(req_data_sel), .req_entry(req_entry),
        .req_cancel(req_cancel), .tlb_busy(tlb_busy),
        .tlb_rd_vld(tlb_rd_vld), .tlb_rd_entry(tlb_rd_entry),
        .lsu_tlb_data_rd_vld_g(lsu_tlb_data_rd_vld_g),
        .lsu_tlb_rd_data(lsu_tlb_rd_data),
        .tte_data_parity_error(tte_data_parity_error),
        .tte_tag_parity_error(tte_tag_parity_error),
        .req_ack(req_ack), .rsp_vld(rsp_vld), .rsp_tid(rsp_tid),
        .rsp_data(rsp_data), .rsp_perr(rsp_perr), .rsp_rdy(rsp_rdy)
    );

    task automatic nxt();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        arst_l     = 1'b0;
        req_vld    = '0;
        req_cancel = '0;
        tlb_busy   = 1'b0;
        nxt();
        nxt();
        arst_l = 1'b1;
    endtask

    task automatic test_reset();
        arst_l = 1'b0; req_vld = '0; req_data_sel = '0; req_entry = '0; req_cancel = '0;
        tlb_busy = 1'b0; lsu_tlb_rd_data = '0; tte_data_parity_error = 1'b0;
        tte_tag_parity_error = 1'b0; rsp_rdy = 1'b1;
        #2;
        n_cmp++;
        if ({tlb_rd_vld, tlb_rd_entry, lsu_tlb_data_rd_vld_g, req_ack, rsp_vld, rsp_tid, rsp_perr} !== 16'd0) begin
            n_err++; $display("FAIL reset_ctl: got %h want 0", {tlb_rd_vld, tlb_rd_entry, lsu_tlb_data_rd_vld_g, req_ack, rsp_vld, rsp_tid, rsp_perr});
        end
        n_cmp++;
        if (rsp_data !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", rsp_data); end
        nxt();
        nxt();
        arst_l = 1'b1;
    endtask

    task automatic test_single_tag();
        req_vld = 4'b0100; req_data_sel[2] = 1'b0; req_entry[17:12] = 6'h15; rsp_rdy = 1'b1;
        #1;
        n_cmp++; if (req_ack !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b want 0100", req_ack); end
        nxt();
        req_vld = '0;
        #1;
        n_cmp++;
        if (tlb_rd_vld !== 1'b1 || tlb_rd_entry !== 6'h15 || lsu_tlb_data_rd_vld_g !== 1'b0) begin
            n_err++; $display("FAIL single_issue: got vld=%b ent=%h sel=%b want 1 15 0", tlb_rd_vld, tlb_rd_entry, lsu_tlb_data_rd_vld_g);
        end
        nxt();
        nxt();
        lsu_tlb_rd_data = 64'hDEAD_BEEF_0123_4567; tte_data_parity_error = 1'b1; tte_tag_parity_error = 1'b0;
        #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL single_early: got rsp_vld=%b want 0", rsp_vld); end
        nxt();
        lsu_tlb_rd_data = '0; tte_data_parity_error = 1'b0;
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_tid !== 2'd2 || rsp_data !== 64'hDEAD_BEEF_0123_4567 || rsp_perr !== 1'b0) begin
            n_err++; $display("FAIL single_rsp: got vld=%b tid=%0d data=%h perr=%b want 1 2 deadbeef01234567 0", rsp_vld, rsp_tid, rsp_data, rsp_perr);
        end
        nxt();
        #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL single_done: got rsp_vld=%b want 0", rsp_vld); end
    endtask

    task automatic test_round_robin();
        int ng = 0;
        int rdcnt = 0;
        int gcyc[5];
        int gtid[5];
        do_reset();
        req_vld = 4'hF; rsp_rdy = 1'b1;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            #1;
            if (tlb_rd_vld) rdcnt++;
            if (|req_ack) begin
                gcyc[ng] = c;
                gtid[ng] = req_ack[0] ? 0 : req_ack[1] ? 1 : req_ack[2] ? 2 : 3;
                if (ng > 0) begin
                    n_cmp++;
                    if (rdcnt !== 1) begin n_err++; $display("FAIL rr_outstanding: got %0d reads want 1", rdcnt); end
                end
                rdcnt = 0;
                ng++;
            end
            nxt();
        end
        n_cmp++;
        if (ng !== 5) begin n_err++; $display("FAIL rr_count: got %0d grants want 5", ng); end
        for (int i = 0; i < ng; i++) begin
            n_cmp++;
            if (gtid[i] !== i % 4) begin n_err++; $display("FAIL rr_order: grant %0d got %0d want %0d", i, gtid[i], i % 4); end
            if (i > 0) begin
                n_cmp++;
                if (gcyc[i] - gcyc[i-1] !== 5) begin n_err++; $display("FAIL rr_gap: got %0d want 5", gcyc[i] - gcyc[i-1]); end
            end
        end
        req_vld = '0;
        repeat (8) nxt();
    endtask

    task automatic test_busy_stall();
        do_reset();
        req_vld = 4'b0001; req_data_sel[0] = 1'b1; req_entry[5:0] = 6'h2A; tlb_busy = 1'b1;
        #1;
        n_cmp++; if (req_ack !== 4'b0001) begin n_err++; $display("FAIL busy_ack: got %b want 0001", req_ack); end
        nxt();
        req_vld = '0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_cmp++;
            if (tlb_rd_vld !== 1'b0 || lsu_tlb_data_rd_vld_g !== 1'b1) begin
                n_err++; $display("FAIL busy_hold: cyc %0d got vld=%b sel=%b want 0 1", c, tlb_rd_vld, lsu_tlb_data_rd_vld_g);
            end
            nxt();
        end
        tlb_busy = 1'b0;
        #1;
        n_cmp++;
        if (tlb_rd_vld !== 1'b1 || tlb_rd_entry !== 6'h2A) begin
            n_err++; $display("FAIL busy_issue: got vld=%b ent=%h want 1 2a", tlb_rd_vld, tlb_rd_entry);
        end
        nxt();
        nxt();
        lsu_tlb_rd_data = 64'hA5A5_0000_FFFF_1234;
        #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL busy_early: got rsp_vld=%b want 0", rsp_vld); end
        nxt();
        lsu_tlb_rd_data = '0;
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_data !== 64'hA5A5_0000_FFFF_1234 || rsp_tid !== 2'd0) begin
            n_err++; $display("FAIL busy_rsp: got vld=%b data=%h tid=%0d want 1 a5a50000ffff1234 0", rsp_vld, rsp_data, rsp_tid);
        end
        nxt();
    endtask

    task automatic test_backpressure_parity();
        req_vld = 4'b0010; req_data_sel[1] = 1'b1; req_entry[11:6] = 6'h3F; rsp_rdy = 1'b0;
        #1;
        n_cmp++; if (req_ack !== 4'b0010) begin n_err++; $display("FAIL bp_ack: got %b want 0010", req_ack); end
        nxt();
        req_vld = '0;
        #1;
        n_cmp++;
        if (tlb_rd_vld !== 1'b1 || tlb_rd_entry !== 6'h3F || lsu_tlb_data_rd_vld_g !== 1'b1) begin
            n_err++; $display("FAIL bp_issue: got vld=%b ent=%h sel=%b want 1 3f 1", tlb_rd_vld, tlb_rd_entry, lsu_tlb_data_rd_vld_g);
        end
        nxt();
        nxt();
        lsu_tlb_rd_data = 64'h0123_4567_89AB_CDEF; tte_data_parity_error = 1'b1; tte_tag_parity_error = 1'b0;
        nxt();
        lsu_tlb_rd_data = '1; tte_data_parity_error = 1'b0; tte_tag_parity_error = 1'b1;
        for (int c = 4; c <= 7; c++) begin
            if (c == 7) rsp_rdy = 1'b1;
            #1;
            n_cmp++;
            if (rsp_vld !== 1'b1 || rsp_tid !== 2'd1 || rsp_data !== 64'h0123_4567_89AB_CDEF || rsp_perr !== 1'b1) begin
                n_err++; $display("FAIL bp_hold: cyc %0d got vld=%b tid=%0d data=%h perr=%b want 1 1 0123456789abcdef 1", c, rsp_vld, rsp_tid, rsp_data, rsp_perr);
            end
            nxt();
        end
        tte_tag_parity_error = 1'b0; lsu_tlb_rd_data = '0;
        #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL bp_done: got rsp_vld=%b want 0", rsp_vld); end
    endtask

    task automatic test_cancel_wait();
        req_vld = 4'b0010; req_data_sel[2] = 1'b0; req_entry[17:12] = 6'h0C; rsp_rdy = 1'b1;
        #1;
        n_cmp++; if (req_ack !== 4'b0010) begin n_err++; $display("FAIL cxl_ack: got %b want 0010", req_ack); end
        nxt();
        req_vld = '0;
        #1;
        n_cmp++; if (tlb_rd_vld !== 1'b1) begin n_err++; $display("FAIL cxl_issue: got %b want 1", tlb_rd_vld); end
        nxt();
        req_cancel = 4'b0010; req_vld = 4'b0100;
        #1;
        n_cmp++; if (req_ack !== 4'b0000) begin n_err++; $display("FAIL cxl_busy_ack: got %b want 0000", req_ack); end
        nxt();
        req_cancel = '0; lsu_tlb_rd_data = 64'h1111_2222_3333_4444;
        #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL cxl_cap: got rsp_vld=%b want 0", rsp_vld); end
        nxt();
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b0 || req_ack !== 4'b0100) begin
            n_err++; $display("FAIL cxl_regrant: got vld=%b ack=%b want 0 0100", rsp_vld, req_ack);
        end
        nxt();
        req_vld = '0;
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b0 || tlb_rd_vld !== 1'b1 || tlb_rd_entry !== 6'h0C) begin
            n_err++; $display("FAIL cxl_next_issue: got rsp=%b vld=%b ent=%h want 0 1 0c", rsp_vld, tlb_rd_vld, tlb_rd_entry);
        end
        nxt();
        nxt();
        lsu_tlb_rd_data = 64'h55AA_55AA_0F0F_F0F0; tte_tag_parity_error = 1'b1; tte_data_parity_error = 1'b0;
        nxt();
        lsu_tlb_rd_data = '0; tte_tag_parity_error = 1'b0;
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_tid !== 2'd2 || rsp_data !== 64'h55AA_55AA_0F0F_F0F0 || rsp_perr !== 1'b1) begin
            n_err++; $display("FAIL cxl_next_rsp: got vld=%b tid=%0d data=%h perr=%b want 1 2 55aa55aa0f0ff0f0 1", rsp_vld, rsp_tid, rsp_data, rsp_perr);
        end
        nxt();
    endtask

    task automatic test_reset_mid();
        req_vld = 4'b1000; req_data_sel[3] = 1'b1; req_entry[23:18] = 6'h11;
        #1;
        n_cmp++; if (req_ack !== 4'b1000) begin n_err++; $display("FAIL rmid_ack: got %b want 1000", req_ack); end
        nxt();
        req_vld = '0;
        nxt();
        lsu_tlb_rd_data = 64'hFFFF_0000_FFFF_0000;
        #1;
        n_cmp++;
        if (lsu_tlb_data_rd_vld_g !== 1'b1 || tlb_rd_entry !== 6'h11) begin
            n_err++; $display("FAIL rmid_wait: got sel=%b ent=%h want 1 11", lsu_tlb_data_rd_vld_g, tlb_rd_entry);
        end
        arst_l = 1'b0;
        #1;
        n_cmp++;
        if ({tlb_rd_vld, tlb_rd_entry, lsu_tlb_data_rd_vld_g, req_ack, rsp_vld, rsp_tid, rsp_perr} !== 16'd0 || rsp_data !== 64'd0) begin
            n_err++; $display("FAIL rmid_zero: got ctl=%h data=%h want 0 0", {tlb_rd_vld, tlb_rd_entry, lsu_tlb_data_rd_vld_g, req_ack, rsp_vld, rsp_tid, rsp_perr}, rsp_data);
        end
        nxt();
        arst_l = 1'b1; req_vld = 4'hF; lsu_tlb_rd_data = '0;
        #1;
        n_cmp++; if (req_ack !== 4'b0001) begin n_err++; $display("FAIL rmid_regrant: got %b want 0001", req_ack); end
        nxt();
        req_vld = '0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_tag();
        test_round_robin();
        test_busy_stall();
        test_backpressure_parity();
        test_cancel_wait();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
